// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//   Shares a single-port memory between the CPU multicycle datapath and a
//   secondary master (DMA / program loader). A granted request is latched,
//   presented to the memory for MEM_LATENCY cycles, read data is captured
//   into the owner's rdata register, and completion is signalled by a
//   one-cycle done pulse on the owner's port.
//   Arbitration favours the CPU. A streak counter lets a pending DMA request
//   win once the CPU has taken MAX_CPU_STREAK grants in a row.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request; cpu_rdata, cpu_done, cpu_stall
//   dma_req/we/addr/wdata       DMA request; dma_rdata, dma_done
//   mem_en/we/addr/wdata        memory macro drive; mem_rdata from macro
//   busy                        access or completion in progress
//   owner                       0 = CPU, 1 = DMA (current or last access)
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_LATENCY    = 2,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LAST   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] streak;
  logic       grant_dma;

  // DMA wins when it is the only requester, or when the CPU has used up
  // its allowed streak while DMA was waiting.
  always_comb begin
    grant_dma = dma_req & (~cpu_req | (streak == STREAK_MAX));
  end

  assign cpu_stall = cpu_req & ~cpu_done;

  // mem_addr/mem_wdata double as the request latches; mem_we is the latched
  // write flag, cleared outside ACCESS so the macro never sees a stray write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            owner     <= grant_dma;
            mem_we    <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
            if (grant_dma || !dma_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 4'd1;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            if (!mem_we) begin
              if (owner) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= ~owner;
            dma_done <= owner;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          mem_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
